// File: rtl/round_key_bank_controller.sv
// round_key_bank_controller: sequences AES-256 rekeying through a shadow bank swapped into the active bank at a safe boundary
module round_key_bank_controller #(
    parameter int NB_BYTE        = 8,
    parameter int N_BYTES_STATE  = 16,
    parameter int N_BYTES_KEY    = 32,
    parameter int N_ROUNDS       = 14,
    parameter int NB_TIMEOUT     = 6,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic                                          i_valid,
    input  logic                                          i_key_update_req,
    input  logic [N_BYTES_KEY*NB_BYTE-1:0]                i_new_key,
    output logic                                          o_key_update_ack,
    output logic                                          o_busy,
    output logic [N_BYTES_KEY*NB_BYTE-1:0]                o_sched_key,
    output logic                                          o_sched_trigger,
    input  logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0] i_sched_round_key_vector,
    input  logic                                          i_sched_output_ready,
    input  logic                                          i_swap_allowed,
    output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0] o_round_key_vector,
    output logic                                          o_key_valid,
    output logic                                          o_key_switch,
    output logic                                          o_timeout_error
);
    localparam int W_KEY = N_BYTES_KEY*NB_BYTE;
    localparam int W_VEC = N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1);

    typedef enum logic [1:0] {S_IDLE, S_TRIGGER, S_WAIT, S_PENDING} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [W_KEY-1:0]        r_key;
    logic [W_VEC-1:0]        r_shadow;
    logic [W_VEC-1:0]        r_active;
    logic [NB_TIMEOUT-1:0]   r_cnt;
    logic                    r_key_valid;
    logic                    r_timeout;
    logic                    w_accept;
    logic                    w_trigger;
    logic                    w_ready;
    logic                    w_expire;
    logic                    w_swap;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else if (i_valid)
            r_state <= w_next;
    end

    always_comb begin
        w_accept  = i_valid && r_state == S_IDLE && i_key_update_req;
        w_trigger = i_valid && r_state == S_TRIGGER;
        w_ready   = i_valid && r_state == S_WAIT && i_sched_output_ready;
        w_expire  = i_valid && r_state == S_WAIT && !i_sched_output_ready
                    && r_cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
        w_swap    = i_valid && r_state == S_PENDING && (i_swap_allowed || !r_key_valid);
        w_next    = w_accept           ? S_TRIGGER :
                    w_trigger          ? S_WAIT    :
                    w_ready            ? S_PENDING :
                    (w_expire||w_swap) ? S_IDLE    : r_state;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_key       <= '0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (i_valid) begin
            if (w_accept)
                r_key <= i_new_key;
            if (r_state == S_TRIGGER)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
            if (w_ready)
                r_shadow <= i_sched_round_key_vector;
            if (w_expire)
                r_timeout <= 1'b1;
            if (w_swap) begin
                r_active    <= r_shadow;
                r_key_valid <= 1'b1;
            end
        end
    end

    assign o_key_update_ack   = w_accept && !i_reset;
    assign o_sched_trigger    = w_trigger && !i_reset;
    assign o_key_switch       = w_swap && !i_reset;
    assign o_busy             = r_state != S_IDLE;
    assign o_sched_key        = r_key;
    assign o_round_key_vector = r_active;
    assign o_key_valid        = r_key_valid;
    assign o_timeout_error    = r_timeout;
endmodule

// File: tb/tb_round_key_bank_controller.sv
// tb_round_key_bank_controller: directed rekey scenarios against a stub AES-256 scheduler and a round-key scoreboard
module tb_round_key_bank_controller;
    logic            i_clock = 1'b0;
    logic            i_reset;
    logic            i_valid;
    logic            i_key_update_req;
    logic [255:0]    i_new_key;
    logic            o_key_update_ack;
    logic            o_busy;
    logic [255:0]    o_sched_key;
    logic            o_sched_trigger;
    logic [1919:0]   i_sched_round_key_vector;
    logic            i_sched_output_ready;
    logic            i_swap_allowed;
    logic [1919:0]   o_round_key_vector;
    logic            o_key_valid;
    logic            o_key_switch;
    logic            o_timeout_error;

    int total = 0;
    int bad = 0;
    int n_ack = 0;
    int n_trig = 0;
    int n_sw = 0;
    bit pend_cmp = 1'b0;
    logic [1919:0] sb [$];
    logic [7:0] sbox_t [256];

    bit stub_en = 1'b1;
    int lat = 16;
    int stub_cnt = 0;
    logic [1919:0] stub_vec = '0;

    round_key_bank_controller dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_key_update_req(i_key_update_req), .i_new_key(i_new_key),
        .o_key_update_ack(o_key_update_ack), .o_busy(o_busy),
        .o_sched_key(o_sched_key), .o_sched_trigger(o_sched_trigger),
        .i_sched_round_key_vector(i_sched_round_key_vector),
        .i_sched_output_ready(i_sched_output_ready), .i_swap_allowed(i_swap_allowed),
        .o_round_key_vector(o_round_key_vector), .o_key_valid(o_key_valid),
        .o_key_switch(o_key_switch), .o_timeout_error(o_timeout_error)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    // FIPS-197 AES-256 expansion; round key 0 occupies the most significant 128 bits
    function automatic logic [1919:0] expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1919:0] v;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) v[1919-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return v;
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [1919:0] obs, input logic [1919:0] exp);
        int r;
        total++;
        assert (obs === exp) else begin
            r = 0;
            for (int i = 0; i < 15; i++) if (obs[1919-128*i -: 128] !== exp[1919-128*i -: 128]) r = i;
            bad++;
            $error("FAIL %s rk=%0d observed=%h expected=%h", tag, r, obs[1919-128*r -: 128], exp[1919-128*r -: 128]);
        end
    endtask

    // stub scheduler: ready after lat valid cycles, held until a valid cycle consumes it
    always @(posedge i_clock) begin
        if (i_valid && o_sched_trigger) begin
            stub_cnt <= lat;
            stub_vec <= expand(o_sched_key);
        end else if (i_valid && stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign i_sched_output_ready     = stub_en && stub_cnt == 1;
    assign i_sched_round_key_vector = stub_vec;

    always @(negedge i_clock) begin
        chk("pulse_gate", {o_key_update_ack, o_sched_trigger, o_key_switch} & {3{~i_valid}}, 0);
        if (pend_cmp) begin
            pend_cmp = 1'b0;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk_vec("sb_vector", o_round_key_vector, sb.pop_front());
        end
        if (o_key_switch) pend_cmp = 1'b1;
        n_ack  += int'(o_key_update_ack);
        n_trig += int'(o_sched_trigger);
        n_sw   += int'(o_key_switch);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic start(input logic [255:0] k);
        i_key_update_req = 1'b1;
        i_new_key = k;
        i_valid = 1'b1;
        @(negedge i_clock);
        chk("ack", o_key_update_ack, 1);
        step(1);
        i_key_update_req = 1'b0;
        @(negedge i_clock);
        chk("trigger", o_sched_trigger, 1);
        chk("sched_key", o_sched_key, k);
        step(1);
    endtask

    task automatic run(input bit gap, output int nv);
        int guard = 0;
        nv = 0;
        while (o_busy && guard < 300) begin
            i_valid = gap ? ~i_valid : 1'b1;
            @(negedge i_clock);
            if (i_valid) nv++;
            @(posedge i_clock);
            #1;
            guard++;
        end
        chk("run_idle", o_busy, 0);
        i_valid = 1'b1;
    endtask

    initial begin
        logic [255:0] k1, k2, k3, k4, k5, k6;
        logic [7:0] inv, b;
        int nv, a0, t0, s0;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        k1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        i_reset = 1'b1; i_valid = 1'b1; i_key_update_req = 1'b1; i_new_key = k1; i_swap_allowed = 1'b0;
        step(2);
        @(negedge i_clock);
        chk("rst_busy", o_busy, 0);
        chk("rst_key_valid", o_key_valid, 0);
        chk("rst_timeout", o_timeout_error, 0);
        chk("rst_sched_key", o_sched_key, 0);
        chk("rst_pulses", {o_key_update_ack, o_sched_trigger, o_key_switch}, 0);
        chk_vec("rst_vector", o_round_key_vector, '0);
        step(1);
        i_reset = 1'b0;
        // first key swaps without a boundary
        sb.push_back(expand(k1));
        start(k1);
        run(0, nv);
        chk("first_latency", nv, 17);
        chk("first_key_valid", o_key_valid, 1);
        chk("fips_rk14", o_round_key_vector[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        chk("fips_rk01", o_round_key_vector[1919:1664], k1);
        step(1);
        chk("first_counts", {n_ack[7:0], n_trig[7:0], n_sw[7:0]}, 24'h010101);
        // gated swap
        k2 = rand_key();
        sb.push_back(expand(k2));
        start(k2);
        step(30);
        chk("gated_busy", o_busy, 1);
        chk_vec("gated_old", o_round_key_vector, expand(k1));
        chk("gated_no_switch", n_sw, 1);
        i_swap_allowed = 1'b1;
        @(negedge i_clock);
        chk("gated_switch", o_key_switch, 1);
        chk_vec("gated_old_on_switch", o_round_key_vector, expand(k1));
        step(1);
        i_swap_allowed = 1'b0;
        chk_vec("gated_new", o_round_key_vector, expand(k2));
        chk("gated_idle", o_busy, 0);
        chk("gated_one_switch", n_sw, 2);
        // request during WAIT is held off until IDLE
        i_swap_allowed = 1'b1;
        k3 = rand_key();
        k4 = rand_key();
        sb.push_back(expand(k3));
        start(k3);
        step(5);
        i_key_update_req = 1'b1;
        i_new_key = k4;
        sb.push_back(expand(k4));
        @(negedge i_clock);
        chk("busy_no_ack", o_key_update_ack, 0);
        chk("busy_key_stable", o_sched_key, k3);
        step(1);
        a0 = n_ack;
        run(0, nv);
        chk("busy_acks_held", n_ack, a0);
        start(k4);
        run(0, nv);
        step(1);
        chk("busy_acked_once", n_ack, a0 + 1);
        chk("busy_switches", n_sw, 4);
        // valid gaps
        k5 = rand_key();
        a0 = n_ack; t0 = n_trig; s0 = n_sw;
        sb.push_back(expand(k5));
        start(k5);
        run(1, nv);
        chk("gap_valid_cycles", nv, 17);
        step(1);
        chk("gap_pulses", {n_ack - a0, n_trig - t0, n_sw - s0}, {32'd1, 32'd1, 32'd1});
        // ready on the last watchdog cycle wins
        lat = 32;
        k6 = rand_key();
        sb.push_back(expand(k6));
        start(k6);
        run(0, nv);
        chk("ready32_cycles", nv, 33);
        chk("ready32_no_error", o_timeout_error, 0);
        chk_vec("ready32_vector", o_round_key_vector, expand(k6));
        // watchdog expiry
        stub_en = 1'b0;
        s0 = n_sw;
        start(rand_key());
        run(0, nv);
        chk("wd_cycles", nv, 32);
        chk("wd_error", o_timeout_error, 1);
        chk("wd_key_valid", o_key_valid, 1);
        chk_vec("wd_vector", o_round_key_vector, expand(k6));
        start(rand_key());
        run(1, nv);
        chk("wd_gap_cycles", nv, 32);
        step(1);
        chk("wd_no_switch", n_sw, s0);
        // error is sticky across a good rekey
        stub_en = 1'b1;
        lat = 16;
        k1 = rand_key();
        sb.push_back(expand(k1));
        start(k1);
        run(0, nv);
        chk("wd_sticky", o_timeout_error, 1);
        // reset during WAIT
        step(1);
        s0 = n_sw;
        start(rand_key());
        step(5);
        i_reset = 1'b1;
        step(1);
        chk("rwait_busy", o_busy, 0);
        chk("rwait_outs", {o_sched_key, o_key_valid, o_timeout_error}, 0);
        chk_vec("rwait_vector", o_round_key_vector, '0);
        @(negedge i_clock);
        chk("rwait_pulses", {o_key_update_ack, o_sched_trigger, o_key_switch}, 0);
        step(1);
        i_reset = 1'b0;
        // reset during PENDING
        k2 = rand_key();
        sb.push_back(expand(k2));
        start(k2);
        run(0, nv);
        i_swap_allowed = 1'b0;
        start(rand_key());
        step(30);
        chk("rpend_busy_before", o_busy, 1);
        s0 = n_sw;
        i_reset = 1'b1;
        step(1);
        chk("rpend_busy", o_busy, 0);
        chk("rpend_outs", {o_sched_key, o_key_valid, o_timeout_error}, 0);
        chk_vec("rpend_vector", o_round_key_vector, '0);
        i_reset = 1'b0;
        step(2);
        chk("rpend_no_switch", n_sw, s0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
